// File: rtl/diffio_pkg.sv
// Shared definitions for the multi-channel diffio pattern generator:
// mode/state encodings, PRBS taps and seed helpers.
package diffio_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS  = 2'd0,
    MODE_ALT   = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_CONST = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int unsigned PRBS_TAP_A = 30;
  localparam int unsigned PRBS_TAP_B = 27;

  function automatic logic [31:0] rotl32(input logic [31:0] value, input int unsigned amount);
    logic [31:0] r;
    r = value;
    for (int unsigned k = 0; k < (amount % 32); k++) begin
      r = {r[30:0], r[31]};
    end
    return r;
  endfunction

  // An all-zero [30:0] would never leave zero through the feedback taps.
  function automatic logic [31:0] fix_seed(input logic [31:0] seed);
    logic [31:0] s;
    s = seed;
    if (s[30:0] == '0) s[0] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/diffio_lfsr_channel.sv
// One PRBS channel: 32-bit Fibonacci LFSR, output is the MSB.
module diffio_lfsr_channel
  import diffio_pkg::*;
#(
  parameter logic [31:0] CH_SEED = 32'hABCDEF01
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLK_EN,
  input  logic SHIFT,
  input  logic RESEED,
  output logic BIT
);

  localparam logic [31:0] SEED_FIXED = fix_seed(CH_SEED);

  logic [31:0] d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      d <= SEED_FIXED;
    end else if (CLK_EN) begin
      if (RESEED) begin
        d <= SEED_FIXED;
      end else if (SHIFT) begin
        d <= {d[30:0], d[PRBS_TAP_A] ^ d[PRBS_TAP_B]};
      end
    end
  end

  assign BIT = d[31];

endmodule

// File: rtl/diffio_pattern_generator_mc.sv
// Multi-channel pattern generator (PRBS / alternating / walking-one / constant)
// driving NUM_CHANNELS differential driver inputs with a programmable bit period.
module diffio_pattern_generator_mc
  import diffio_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 8,
  parameter logic [31:0] SEED         = 32'hABCDEF01,
  parameter int unsigned BIT_PERIOD   = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CLK_EN,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic [1:0]              MODE,
  input  logic [CNT_WIDTH-1:0]    NUM_BITS,
  input  logic [NUM_CHANNELS-1:0] CONST_PATTERN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    BIT_STROBE,
  output logic [NUM_CHANNELS-1:0] BIT_PATTERN
);

  localparam int unsigned TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int unsigned WW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  state_t                  state_q, state_d;
  mode_t                   mode_q;
  logic [CNT_WIDTH-1:0]    nbits_q;
  logic [NUM_CHANNELS-1:0] const_q;
  logic [TW-1:0]           tick_q;
  logic [CNT_WIDTH-1:0]    bit_cnt_q;
  logic [WW-1:0]           walk_q;

  logic                    load;
  logic                    shift;
  logic                    reseed;
  logic                    tick_last;
  logic [NUM_CHANNELS-1:0] prbs_bits;
  logic [NUM_CHANNELS-1:0] pattern;

  assign tick_last = (tick_q == TW'(BIT_PERIOD - 1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    reseed  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START && !ABORT && (NUM_BITS != '0)) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (ABORT) begin
          state_d = IDLE;
          reseed  = 1'b1;
        end else if (tick_last) begin
          shift = 1'b1;
          if (bit_cnt_q == nbits_q - CNT_WIDTH'(1)) state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        reseed  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      mode_q    <= MODE_PRBS;
      nbits_q   <= '0;
      const_q   <= '0;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      walk_q    <= '0;
    end else if (CLK_EN) begin
      state_q <= state_d;
      if (load) begin
        mode_q  <= mode_t'(MODE);
        nbits_q <= NUM_BITS;
        const_q <= CONST_PATTERN;
      end
      // Counters only live while staying in RUN; any other path clears them.
      if (state_q != RUN || state_d != RUN) begin
        tick_q    <= '0;
        bit_cnt_q <= '0;
        walk_q    <= '0;
      end else if (tick_last) begin
        tick_q    <= '0;
        bit_cnt_q <= bit_cnt_q + CNT_WIDTH'(1);
        walk_q    <= (walk_q == WW'(NUM_CHANNELS - 1)) ? '0 : walk_q + WW'(1);
      end else begin
        tick_q <= tick_q + TW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lfsr
    diffio_lfsr_channel #(
      .CH_SEED(rotl32(SEED, g))
    ) u_lfsr (
      .CLK   (CLK),
      .RST   (RST),
      .CLK_EN(CLK_EN),
      .SHIFT (shift),
      .RESEED(reseed),
      .BIT   (prbs_bits[g])
    );
  end

  always_comb begin
    pattern = '0;
    case (mode_q)
      MODE_PRBS:  pattern = prbs_bits;
      MODE_ALT: begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
          pattern[i] = ~(bit_cnt_q[0] ^ i[0]);
        end
      end
      MODE_WALK: begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
          pattern[i] = (walk_q == WW'(i));
        end
      end
      MODE_CONST: pattern = const_q;
      default:    pattern = '0;
    endcase
  end

  assign BUSY        = (state_q == RUN);
  assign DONE        = (state_q == FINISH) && CLK_EN;
  assign BIT_STROBE  = (state_q == RUN) && (tick_q == '0) && CLK_EN;
  assign BIT_PATTERN = (state_q == RUN) ? pattern : '0;

endmodule

// File: tb/tb_diffio_pattern_generator_mc.sv
// Self-checking bench: directed scenarios plus randomized traffic, all checked
// every cycle against a run-position based behavioural model.
module tb_diffio_pattern_generator_mc;

  localparam int          NC   = 8;
  localparam int          BP   = 2;
  localparam int          CW   = 32;
  localparam logic [31:0] SEED = 32'hABCDEF01;

  logic          CLK;
  logic          RST;
  logic          CLK_EN;
  logic          START;
  logic          ABORT;
  logic [1:0]    MODE;
  logic [CW-1:0] NUM_BITS;
  logic [NC-1:0] CONST_PATTERN;
  logic          BUSY;
  logic          DONE;
  logic          BIT_STROBE;
  logic [NC-1:0] BIT_PATTERN;

  diffio_pattern_generator_mc #(
    .NUM_CHANNELS(NC),
    .SEED        (SEED),
    .BIT_PERIOD  (BP),
    .CNT_WIDTH   (CW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .CLK_EN       (CLK_EN),
    .START        (START),
    .ABORT        (ABORT),
    .MODE         (MODE),
    .NUM_BITS     (NUM_BITS),
    .CONST_PATTERN(CONST_PATTERN),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .BIT_STROBE   (BIT_STROBE),
    .BIT_PATTERN  (BIT_PATTERN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            chk_en = 0;
  bit            m_busy = 0;
  bit            m_finish = 0;
  longint        m_pos = 0;
  longint        m_n = 0;
  logic [1:0]    m_mode = 0;
  logic [NC-1:0] m_const = 0;

  function automatic logic prbs_bit(input int ch, input longint k);
    logic [31:0] d;
    d = (ch == 0) ? SEED : ((SEED << ch) | (SEED >> (32 - ch)));
    if (d[30:0] == 31'd0) d[0] = 1'b1;
    for (longint j = 0; j < k; j++) d = {d[30:0], d[30] ^ d[27]};
    return d[31];
  endfunction

  function automatic logic [NC-1:0] exp_pat(input logic [1:0] mode, input longint k,
                                            input logic [NC-1:0] cp);
    logic [NC-1:0] p;
    p = '0;
    for (int ch = 0; ch < NC; ch++) begin
      case (mode)
        2'd0:    p[ch] = prbs_bit(ch, k);
        2'd1:    p[ch] = ((k % 2) == (ch % 2));
        2'd2:    p[ch] = ((k % NC) == ch);
        default: p[ch] = cp[ch];
      endcase
    end
    return p;
  endfunction

  initial begin
    forever begin
      @(posedge CLK);
      if (RST) begin
        m_busy = 0; m_finish = 0; m_pos = 0;
      end else if (CLK_EN) begin
        if (m_finish) begin
          m_finish = 0;
        end else if (m_busy) begin
          if (ABORT) m_busy = 0;
          else if (m_pos == m_n * BP - 1) begin m_busy = 0; m_finish = 1; end
          else m_pos++;
        end else if (START && !ABORT && NUM_BITS != 0) begin
          m_busy = 1; m_pos = 0; m_n = longint'(NUM_BITS);
          m_mode = MODE; m_const = CONST_PATTERN;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [NC+2:0] exp_v;
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        exp_v = {m_busy, m_finish & CLK_EN, m_busy & ((m_pos % BP) == 0) & CLK_EN,
                 m_busy ? exp_pat(m_mode, m_pos / BP, m_const) : {NC{1'b0}}};
        check("outputs", {BUSY, DONE, BIT_STROBE, BIT_PATTERN}, exp_v);
      end
    end
  end

  // ---------------- observation counters for directed checks ----------------
  int            busy_cnt, done_cnt, strobe_cnt, const_cnt;
  logic [31:0]   ch0;
  logic [NC-1:0] pats[$];

  initial begin
    forever begin
      @(negedge CLK);
      if (CLK_EN) begin
        if (BUSY) busy_cnt++;
        if (DONE) done_cnt++;
        if (BUSY && BIT_PATTERN == 8'hA5) const_cnt++;
        if (BIT_STROBE) begin
          strobe_cnt++;
          pats.push_back(BIT_PATTERN);
          ch0 = {ch0[30:0], BIT_PATTERN[0]};
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    busy_cnt = 0; done_cnt = 0; strobe_cnt = 0; const_cnt = 0; ch0 = '0;
    pats.delete();
  endtask

  task automatic start(input logic [1:0] mode, input logic [CW-1:0] n, input logic [NC-1:0] cp);
    MODE = mode; NUM_BITS = n; CONST_PATTERN = cp; START = 1'b1;
    cyc();
    START = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 500 && done_cnt == 0; i++) cyc();
    check(name, (done_cnt != 0), 1);
    cyc();
  endtask

  initial begin
    logic [NC-1:0] walk_exp[10];
    logic [NC-1:0] alt_exp[4];
    logic [31:0]   mword;
    int            c;
    walk_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    alt_exp  = '{8'h55, 8'hAA, 8'h55, 8'hAA};

    // Pin the model with hand-derived values.
    mword = '0;
    for (int k = 0; k < 32; k++) mword = {mword[30:0], prbs_bit(0, k)};
    check("model_prbs_ch0", mword, 32'hABCDEF01);
    check("model_prbs_ch1_first", prbs_bit(1, 0), 0);
    check("model_walk_k9", exp_pat(2'd2, 9, '0), 8'h02);
    check("model_alt_k1", exp_pat(2'd1, 1, '0), 8'hAA);

    RST = 1; CLK_EN = 1; START = 0; ABORT = 0; MODE = 0; NUM_BITS = 0; CONST_PATTERN = 0;
    cyc();
    chk_en = 1;
    cyc();
    check("reset_state", {BUSY, DONE, BIT_STROBE, BIT_PATTERN}, 0);
    RST = 0;
    cyc();

    // PRBS channel 0 reproduces the seed MSB-first.
    clr();
    start(2'd0, 32, '0);
    wait_done("prbs32_done");
    check("prbs32_ch0", ch0, 32'hABCDEF01);
    check("prbs32_strobes", strobe_cnt, 32);
    check("prbs32_busy", busy_cnt, 64);
    check("prbs32_done_cnt", done_cnt, 1);

    // Walking one across 10 bits.
    clr();
    check("walk_pre_zero", BIT_PATTERN, 0);
    start(2'd2, 10, '0);
    wait_done("walk_done");
    check("walk_count", pats.size(), 10);
    for (int i = 0; i < 10 && i < pats.size(); i++) check("walk_pat", pats[i], walk_exp[i]);
    check("walk_post_zero", BIT_PATTERN, 0);

    // Alternating; inputs changed mid-run must be ignored.
    clr();
    start(2'd1, 4, '0);
    cyc();
    MODE = 2'd3; NUM_BITS = 1; CONST_PATTERN = 8'hFF;
    wait_done("alt_done");
    check("alt_count", pats.size(), 4);
    for (int i = 0; i < 4 && i < pats.size(); i++) check("alt_pat", pats[i], alt_exp[i]);

    // Constant with CLK_EN active one cycle in three.
    clr();
    MODE = 2'd3; NUM_BITS = 3; CONST_PATTERN = 8'hA5; START = 1; CLK_EN = 1;
    cyc();
    START = 0;
    c = 1;
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      CLK_EN = (c % 3 == 0);
      c++;
      cyc();
    end
    repeat (6) begin CLK_EN = (c % 3 == 0); c++; cyc(); end
    CLK_EN = 1;
    check("const_held", const_cnt, 6);
    check("const_busy", busy_cnt, 6);
    check("const_done", done_cnt, 1);
    check("const_strobes", strobe_cnt, 3);

    // Abort at bit 5 of a 100-bit PRBS run.
    clr();
    start(2'd0, 100, '0);
    repeat (10) cyc();
    ABORT = 1;
    cyc();
    ABORT = 0;
    check("abort_busy", BUSY, 0);
    check("abort_bits", ch0[5:0], 6'b101010);
    repeat (3) cyc();
    check("abort_no_done", done_cnt, 0);
    clr();
    start(2'd0, 8, '0);
    wait_done("after_abort_done");
    check("after_abort_bits", ch0[7:0], 8'hAB);

    // Zero-length start is ignored.
    clr();
    start(2'd0, 0, '0);
    repeat (5) cyc();
    check("zero_busy", busy_cnt, 0);
    check("zero_done", done_cnt, 0);

    // Reset during a run.
    clr();
    start(2'd0, 20, '0);
    repeat (7) cyc();
    RST = 1;
    cyc();
    check("rst_outputs", {BUSY, BIT_STROBE, BIT_PATTERN}, 0);
    RST = 0;
    repeat (3) cyc();
    check("rst_no_done", done_cnt, 0);
    clr();
    start(2'd0, 8, '0);
    wait_done("after_rst_done");
    check("after_rst_bits", ch0[7:0], 8'hAB);

    // Randomized traffic, checked by the per-cycle model comparison.
    repeat (4000) begin
      CLK_EN        = ($urandom % 5) != 0;
      RST           = ($urandom % 300) == 0;
      ABORT         = ($urandom % 60) == 0;
      START         = ($urandom % 4) == 0;
      MODE          = 2'($urandom);
      NUM_BITS      = CW'($urandom_range(0, 12));
      CONST_PATTERN = NC'($urandom);
      cyc();
    end
    RST = 0; ABORT = 0; START = 0; CLK_EN = 1;
    repeat (60) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/diffio_pattern_generator_mc.md
Name: diffio_pattern_generator_mc

Overview:
Multi-channel, multi-mode successor of the single-channel diffio pattern generator. It drives NUM_CHANNELS inputs of the SN65MLVD080DGG differential drivers on the DUT board in parallel. Each run produces a programmable number of bits, with a programmable bit period. Modes are PRBS, alternating, walking-one and constant. It sits between the test-control register block and the diffio checker, which aligns to BIT_STROBE.

Parameters:
NUM_CHANNELS, 8, number of parallel pattern outputs (1..32).
SEED, 32'hABCDEF01, base PRBS seed for channel 0.
BIT_PERIOD, 2, CLK_EN ticks per bit (>=1).
CNT_WIDTH, 32, width of the NUM_BITS input and the bit counter.

Ports:
CLK  in  1  system clock (50 MHz).
RST  in  1  synchronous, active-high reset.
CLK_EN  in  1  clock enable; all state, counters and LFSRs advance only when high.
START  in  1  start a run; sampled in IDLE when CLK_EN=1.
ABORT  in  1  terminate a run early.
MODE  in  2  pattern mode: 0 PRBS, 1 ALTERNATING, 2 WALKING_ONE, 3 CONSTANT.
NUM_BITS  in  CNT_WIDTH  bits per channel per run.
CONST_PATTERN  in  NUM_CHANNELS  per-channel level used in CONSTANT mode.
BUSY  out  1  run in progress.
DONE  out  1  one enabled-cycle pulse at normal completion.
BIT_STROBE  out  1  high on the first tick of each bit.
BIT_PATTERN  out  NUM_CHANNELS  generated levels.

Behaviour:
- Reset (RST=1 at a CLK edge), regardless of CLK_EN:
  - state=IDLE; all counters cleared; LFSRs loaded with their seeds.
  - BUSY=0, DONE=0, BIT_STROBE=0, BIT_PATTERN=0.
  - A reset during RUN aborts silently; no DONE.
- All transitions below occur only at CLK edges with CLK_EN=1. With CLK_EN=0 every register holds.
- States: IDLE, RUN, FINISH.
- IDLE:
  - Transition to RUN when START=1, ABORT=0 and NUM_BITS!=0.
  - On that edge, latch MODE, NUM_BITS and CONST_PATTERN. Later changes to these inputs during a run are ignored.
  - START with NUM_BITS=0 is ignored: BUSY stays 0 and no DONE is produced.
  - START and ABORT together in IDLE: ABORT wins; the start is ignored.
- RUN:
  - tick_cnt counts 0..BIT_PERIOD-1.
  - At tick BIT_PERIOD-1, bit_cnt increments and the pattern advances.
  - At tick BIT_PERIOD-1 with bit_cnt==NUM_BITS_latched-1, go to FINISH.
  - ABORT=1 in RUN: go to IDLE on that edge, reseed the LFSRs, clear the counters, no DONE.
- FINISH: lasts exactly one enabled cycle, then goes to IDLE. LFSRs are reseeded on exit.
- Outputs (combinational from state and registers):
  - BUSY = (state==RUN).
  - DONE = (state==FINISH) & CLK_EN.
  - BIT_STROBE = (state==RUN) & (tick_cnt==0) & CLK_EN.
  - BIT_PATTERN = 0 unless state==RUN.
  - Latency: the first bit appears on the cycle after the START edge. Each bit lasts BIT_PERIOD enabled cycles.
- PRBS mode:
  - Per-channel 32-bit register d; output d[31]; shift d <= {d[30:0], d[30]^d[27]}.
  - Channel 0 must be bit-identical to the previous single-channel generator for the same SEED.
  - Channel i seed = SEED rotated left by i.
  - If the seed's bits [30:0] are all zero, force bit0=1 to avoid LFSR lockup.
- ALTERNATING mode: channel i outputs (bit_cnt[0] ^ i[0]) inverted. Even channels start at 1, odd channels start at 0.
- WALKING_ONE mode: channel i is 1 iff (bit_cnt mod NUM_CHANNELS)==i.
  - Use a separate modulo counter that wraps at NUM_CHANNELS-1; no divider.
- CONSTANT mode: BIT_PATTERN = latched CONST_PATTERN for the whole run.
- bit_cnt arithmetic: unsigned, CNT_WIDTH bits. NUM_BITS = 2^CNT_WIDTH-1 must complete without wrap-around.
- Reset out of FINISH takes priority: no DONE is produced.

Decomposition:
- Package diffio_pkg holds:
  - Mode constants MODE_PRBS=2'd0, MODE_ALT=2'd1, MODE_WALK=2'd2, MODE_CONST=2'd3.
  - State encodings IDLE/RUN/FINISH.
  - PRBS tap constants (30, 27).
- Sub-module diffio_lfsr_channel, one instance per channel via generate:
  - Parameter CH_SEED.
  - Inputs CLK, RST, CLK_EN, SHIFT, RESEED.
  - Output BIT (= d[31]).
  - Applies the lockup fix to CH_SEED at elaboration.

Test Plan:
- PRBS, SEED=32'hABCDEF01, BIT_PERIOD=2, NUM_BITS=32, CLK_EN=1 -> channel 0 emits the SEED MSB-first (1,0,1,0,1,0,1,1 ... 0,0,0,0,0,0,0,1), each bit held 2 cycles. Expect 32 BIT_STROBEs, BUSY high 64 cycles, then one DONE pulse.
- WALKING_ONE, NUM_CHANNELS=8, NUM_BITS=10 -> BIT_PATTERN sequence 0x01,0x02,...,0x80,0x01,0x02. BIT_PATTERN=0 before the run and after DONE.
- ALTERNATING, NUM_BITS=4 -> BIT_PATTERN 0x55,0xAA,0x55,0xAA. Change MODE mid-run -> no effect.
- CLK_EN toggling 1-of-3 cycles, CONSTANT, CONST_PATTERN=0xA5, NUM_BITS=3 -> output holds 0xA5 for exactly 6 enabled cycles. DONE high for exactly one enabled cycle.
- ABORT at bit 5 of a 100-bit PRBS run -> BUSY drops next cycle, no DONE. A following START with NUM_BITS=8 reproduces the first 8 seed bits (0xAB).
- START with NUM_BITS=0 -> BUSY stays 0, no DONE. RST during RUN -> all outputs 0 on the next cycle, and a new START then restarts from the seed.
